// File: rtl/shift_arbiter.sv
// rtl/shift_arbiter.sv - two-requester REQ/ACK arbiter in front of one shared SHIFT32
// SHIFT_ARB_FIXED_PRI_EN: requester 0 always wins contention instead of round-robin.

module shift_arbiter (
   input  logic        CLK,
   input  logic        RST,
   input  logic        REQ0,
   input  logic        REQ1,
   input  logic [31:0] D0,
   input  logic [31:0] D1,
   input  logic [31:0] S0,
   input  logic [31:0] S1,
   input  logic        LNR0,
   input  logic        LNR1,
   output logic        ACK0,
   output logic        ACK1,
   output logic [31:0] RES,
   output logic [31:0] SH_D,
   output logic [31:0] SH_S,
   output logic        SH_LNR,
   input  logic [31:0] SH_Y
);

   typedef enum logic [1:0] {IDLE, ISSUE, HOLD} state_t;

   state_t      state_q, state_d;
   logic        win_q, win_d;
   logic        last_q, last_d;
   logic [31:0] opnd_q, opnd_d;
   logic [31:0] amt_q, amt_d;
   logic        lnr_q, lnr_d;
   logic [31:0] res_q, res_d;
   logic        ack0_q, ack0_d;
   logic        ack1_q, ack1_d;
   logic        pick;
   logic        win_req;

   always_comb begin
`ifdef SHIFT_ARB_FIXED_PRI_EN
      pick = ~REQ0;
`else
      // Under contention the requester that did not win last time goes first.
      pick = (REQ0 && REQ1) ? ~last_q : REQ1;
`endif
   end

   assign win_req = win_q ? REQ1 : REQ0;

   always_comb begin
      state_d = state_q;
      win_d   = win_q;
      last_d  = last_q;
      opnd_d  = opnd_q;
      amt_d   = amt_q;
      lnr_d   = lnr_q;
      res_d   = res_q;
      ack0_d  = ack0_q;
      ack1_d  = ack1_q;
      case (state_q)
         IDLE: begin
            if (REQ0 || REQ1) begin
               win_d   = pick;
               last_d  = pick;
               opnd_d  = pick ? D1 : D0;
               amt_d   = pick ? S1 : S0;
               lnr_d   = pick ? LNR1 : LNR0;
               state_d = ISSUE;
            end
         end
         ISSUE: begin
            res_d   = SH_Y;
            ack0_d  = ~win_q;
            ack1_d  = win_q;
            state_d = HOLD;
         end
         HOLD: begin
            // The loser's request is left pending until we are back in IDLE.
            if (!win_req) begin
               ack0_d  = 1'b0;
               ack1_d  = 1'b0;
               state_d = IDLE;
            end
         end
         default: begin
            ack0_d  = 1'b0;
            ack1_d  = 1'b0;
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         state_q <= IDLE;
         win_q   <= 1'b0;
         last_q  <= 1'b1;
         opnd_q  <= 32'd0;
         amt_q   <= 32'd0;
         lnr_q   <= 1'b0;
         res_q   <= 32'd0;
         ack0_q  <= 1'b0;
         ack1_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         win_q   <= win_d;
         last_q  <= last_d;
         opnd_q  <= opnd_d;
         amt_q   <= amt_d;
         lnr_q   <= lnr_d;
         res_q   <= res_d;
         ack0_q  <= ack0_d;
         ack1_q  <= ack1_d;
      end
   end

   assign ACK0   = ack0_q;
   assign ACK1   = ack1_q;
   assign RES    = res_q;
   assign SH_D   = opnd_q;
   assign SH_S   = amt_q;
   assign SH_LNR = lnr_q;

endmodule

// File: tb/tb_shift_arbiter.sv
// tb/tb_shift_arbiter.sv - self-checking bench for shift_arbiter with a behavioural SHIFT32 and arbitration model

module tb_shift_arbiter;

   logic        CLK = 1'b0;
   logic        RST;
   logic        REQ0, REQ1;
   logic [31:0] D0, D1, S0, S1;
   logic        LNR0, LNR1;
   logic        ACK0, ACK1;
   logic [31:0] RES, SH_D, SH_S, SH_Y;
   logic        SH_LNR;

   int chk_cnt  = 0;
   int pass_cnt = 0;

   always #5 CLK = ~CLK;

   // Stand-in for the shared combinational SHIFT32.
   assign SH_Y = SH_LNR ? (SH_D << SH_S) : (SH_D >> SH_S);

   shift_arbiter dut (
      .CLK(CLK), .RST(RST), .REQ0(REQ0), .REQ1(REQ1),
      .D0(D0), .D1(D1), .S0(S0), .S1(S1), .LNR0(LNR0), .LNR1(LNR1),
      .ACK0(ACK0), .ACK1(ACK1), .RES(RES),
      .SH_D(SH_D), .SH_S(SH_S), .SH_LNR(SH_LNR), .SH_Y(SH_Y)
   );

   typedef struct {
      logic        id;
      logic [31:0] d;
      logic [31:0] s;
      logic        lnr;
      logic [31:0] exp;
   } vec_t;

   vec_t vecs[9];

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      chk_cnt++;
      if (got === exp) pass_cnt++;
      else $display("FAIL %s: got %h expected %h", name, got, exp);
   endtask

   function automatic logic [31:0] ref_shift(input logic [31:0] d, input logic [31:0] s, input logic lnr);
      logic [63:0] p;
      if (s >= 32) return 32'd0;
      p = 64'd1 << s[5:0];
      if (lnr) return 32'((64'(d) * p) & 64'hFFFF_FFFF);
      return 32'(64'(d) / p);
   endfunction

   function automatic logic model_pick(input logic both, input logic only_id, input logic last);
`ifdef SHIFT_ARB_FIXED_PRI_EN
      if (both) return 1'b0;
`else
      if (both) return ~last;
`endif
      return only_id;
   endfunction

   task automatic set_req(input logic id, input logic v);
      if (id) REQ1 = v;
      else REQ0 = v;
   endtask

   task automatic set_ops(input logic id, input logic [31:0] d, input logic [31:0] s, input logic lnr);
      if (id) begin D1 = d; S1 = s; LNR1 = lnr; end
      else begin D0 = d; S0 = s; LNR0 = lnr; end
   endtask

   task automatic single_op(input vec_t v, input string name);
      logic a;
      set_ops(v.id, v.d, v.s, v.lnr);
      set_req(v.id, 1'b1);
      tick();
      a = v.id ? ACK1 : ACK0;
      chk({name, "_ack_early"}, 32'(a), 32'd0);
      tick();
      a = v.id ? ACK1 : ACK0;
      chk({name, "_ack"}, 32'(a), 32'd1);
      chk({name, "_other_ack"}, 32'(v.id ? ACK0 : ACK1), 32'd0);
      chk({name, "_res"}, RES, v.exp);
      set_req(v.id, 1'b0);
      tick();
      chk({name, "_release"}, 32'(ACK0 | ACK1), 32'd0);
   endtask

   task automatic wait_ack(output int n);
      n = 0;
      while (!(ACK0 || ACK1) && n < 8) begin
         tick();
         n++;
      end
   endtask

   initial begin
      logic        last_m;
      logic        w;
      int          n;
      logic [1:0]  mask;
      logic [31:0] rd0, rd1, rs0, rs1;
      logic        rl0, rl1;

      vecs[0] = '{1'b0, 32'b11000, 32'd3, 1'b0, 32'b11};
      vecs[1] = '{1'b0, 32'b100, 32'd2, 1'b0, 32'b1};
      vecs[2] = '{1'b0, 32'b100, 32'd3, 1'b0, 32'd0};
      vecs[3] = '{1'b0, 32'd1, 32'd1, 1'b0, 32'd0};
      vecs[4] = '{1'b1, 32'd1, 32'd31, 1'b1, 32'h8000_0000};
      vecs[5] = '{1'b1, 32'd1, 32'd40, 1'b1, 32'd0};
      vecs[6] = '{1'b1, 32'hF000_0000, 32'd4, 1'b0, 32'h0F00_0000};
      vecs[7] = '{1'b0, 32'hFFFF_FFFF, 32'd32, 1'b0, 32'd0};
      vecs[8] = '{1'b0, 32'h1234_5678, 32'd0, 1'b1, 32'h1234_5678};

      // Reset held with a pending request.
      RST = 1'b0; REQ0 = 1'b1; REQ1 = 1'b0;
      D0 = 32'hA5; S0 = 32'd1; LNR0 = 1'b1;
      D1 = 32'd0; S1 = 32'd0; LNR1 = 1'b0;
      tick(); tick();
      chk("rst_ack0", 32'(ACK0), 32'd0);
      chk("rst_ack1", 32'(ACK1), 32'd0);
      chk("rst_res", RES, 32'd0);
      chk("rst_sh_d", SH_D, 32'd0);
      chk("rst_sh_s", SH_S, 32'd0);
      chk("rst_sh_lnr", 32'(SH_LNR), 32'd0);
      RST = 1'b1;
      tick();
      chk("rst_rel_ack_early", 32'(ACK0), 32'd0);
      chk("rst_rel_sh_d", SH_D, 32'hA5);
      tick();
      chk("rst_rel_ack0", 32'(ACK0), 32'd1);
      chk("rst_rel_res", RES, 32'h14A);
      REQ0 = 1'b0;
      tick();

      foreach (vecs[i]) single_op(vecs[i], $sformatf("vec%0d", i));

      // Operand change after grant must not leak into the result.
      D0 = 32'd5; S0 = 32'd1; LNR0 = 1'b1; REQ0 = 1'b1;
      tick();
      D0 = 32'd7;
      tick();
      chk("stab_ack0", 32'(ACK0), 32'd1);
      chk("stab_res", RES, 32'd10);
      REQ0 = 1'b0;
      tick();

      // Winner drops REQ during ISSUE: one-cycle ACK.
      D0 = 32'd9; S0 = 32'd0; REQ0 = 1'b1;
      tick();
      REQ0 = 1'b0;
      tick();
      chk("early_ack_hi", 32'(ACK0), 32'd1);
      chk("early_res", RES, 32'd9);
      tick();
      chk("early_ack_lo", 32'(ACK0), 32'd0);

      // Asynchronous reset during HOLD.
      D0 = 32'd3; S0 = 32'd0; REQ0 = 1'b1;
      tick(); tick();
      chk("midrst_pre_ack", 32'(ACK0), 32'd1);
      #2 RST = 1'b0;
      #1;
      chk("midrst_ack0", 32'(ACK0), 32'd0);
      chk("midrst_res", RES, 32'd0);
      REQ0 = 1'b0;
      tick();
      RST = 1'b1;
      tick();

      // Contention from reset release, winner re-raises right after its ACK.
      RST = 1'b0;
      D0 = 32'd1; S0 = 32'd0; LNR0 = 1'b0;
      D1 = 32'd2; S1 = 32'd0; LNR1 = 1'b0;
      REQ0 = 1'b1; REQ1 = 1'b1;
      tick();
      RST = 1'b1;
      last_m = 1'b1;
      for (int g = 0; g < 4; g++) begin
         wait_ack(n);
         chk($sformatf("cont%0d_seen", g), 32'(ACK0 | ACK1), 32'd1);
         w = model_pick(1'b1, 1'b0, last_m);
         last_m = w;
         chk($sformatf("cont%0d_winner", g), 32'(ACK1), 32'(w));
         chk($sformatf("cont%0d_onehot", g), 32'(ACK0 & ACK1), 32'd0);
         chk($sformatf("cont%0d_res", g), RES, w ? 32'd2 : 32'd1);
         set_req(ACK1, 1'b0);
         tick();
         REQ0 = 1'b1; REQ1 = 1'b1;
      end
      REQ0 = 1'b0; REQ1 = 1'b0;
      tick(); tick(); tick();

      // Randomised transactions against the arbitration/shift model.
      RST = 1'b0;
      tick();
      RST = 1'b1;
      last_m = 1'b1;
      for (int r = 0; r < 40; r++) begin
         mask = 2'($urandom_range(1, 3));
         rd0 = $urandom; rd1 = $urandom;
         rs0 = ($urandom_range(0, 7) == 0) ? 32'($urandom_range(32, 100)) : 32'($urandom_range(0, 31));
         rs1 = ($urandom_range(0, 7) == 0) ? 32'($urandom_range(32, 100)) : 32'($urandom_range(0, 31));
         rl0 = 1'($urandom); rl1 = 1'($urandom);
         set_ops(1'b0, rd0, rs0, rl0);
         set_ops(1'b1, rd1, rs1, rl1);
         REQ0 = mask[0]; REQ1 = mask[1];
         w = model_pick(mask == 2'b11, mask[1], last_m);
         last_m = w;
         tick();
         // Scramble operands after grant; the model keeps the originals.
         D0 = $urandom; D1 = $urandom;
         wait_ack(n);
         chk($sformatf("rnd%0d_latency", r), 32'(n), 32'd1);
         chk($sformatf("rnd%0d_winner", r), 32'(ACK1), 32'(w));
         chk($sformatf("rnd%0d_onehot", r), 32'(ACK0 & ACK1), 32'd0);
         chk($sformatf("rnd%0d_res", r), RES, w ? ref_shift(rd1, rs1, rl1) : ref_shift(rd0, rs0, rl0));
         REQ0 = 1'b0; REQ1 = 1'b0;
         tick();
         chk($sformatf("rnd%0d_release", r), 32'(ACK0 | ACK1), 32'd0);
      end

      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end

endmodule

// File: doc/shift_arbiter.md
# shift_arbiter

Sequencing arbiter that shares one combinational 32-bit barrel shifter (SHIFT32) between two requesters over a 4-phase REQ/ACK handshake. It latches the winner's operand, amount and direction, drives the shifter for one cycle and registers its output. It then holds the result and ACK until the winner releases REQ. It sits between the ALU/address-generation requesters and the single shared SHIFT32 instance.

## Interface
- No parameters; datapath width fixed at 32.
- CLK  input  1  system clock, rising-edge.
- RST  input  1  asynchronous, active-low reset.
- REQ0, REQ1  input  1  request from requester 0 / 1; level, 4-phase.
- D0, D1  input  32  operand from requester 0 / 1; sampled only at grant.
- S0, S1  input  32  shift amount from requester 0 / 1; sampled only at grant.
- LNR0, LNR1  input  1  direction from requester 0 / 1: 1 = left, 0 = right (logical).
- ACK0, ACK1  output  1  completion acknowledge to requester 0 / 1.
- RES  output  32  registered shift result; valid while ACK0 or ACK1 is high.
- SH_D  output  32  operand driven to SHIFT32 D.
- SH_S  output  32  amount driven to SHIFT32 shift.
- SH_LNR  output  1  direction driven to SHIFT32 LnR.
- SH_Y  input  32  SHIFT32 Y, combinational from SH_D/SH_S/SH_LNR.

## Operation
- States: IDLE, ISSUE, HOLD.
- IDLE:
  - no REQ high -> stay in IDLE.
  - any REQ high at a rising edge -> pick a winner, latch its D/S/LNR into SH_D/SH_S/SH_LNR, record its id, go to ISSUE.
- ISSUE: SH_* are stable for one full cycle. At the next edge, RES <= SH_Y, the winner's ACK <= 1, go to HOLD.
- HOLD: RES and ACK are held.
  - winner's REQ sampled low -> ACK <= 0, go to IDLE.
  - the other requester's REQ is ignored, and stays pending, until IDLE.
- Arbitration: round-robin. A LAST register holds the id of the most recent winner.
  - When both REQs are high in IDLE, the requester that is not LAST wins.
  - When only one REQ is high, that requester wins.
  - LAST updates on the IDLE -> ISSUE transition.
- The shift amount passes through unmodified. Values >= 32 are resolved by SHIFT32 and yield 0. The arbiter does no range checking.
- At most one ACK is high at any time.
- Operand changes on Dx/Sx/LNRx after grant have no effect on the in-flight operation.
- Winner dropping REQ during ISSUE: the operation still completes. ACK rises for one cycle in HOLD, then falls at the next edge because REQ is sampled low.

## Timing
- Reset (RST low, asynchronous) forces: state IDLE; ACK0 = ACK1 = 0; RES = 0; SH_D = 0; SH_S = 0; SH_LNR = 0; LAST = 1, so requester 0 wins first.
- Reset mid-operation aborts the operation with no ACK. After RST deasserts, requests are re-sampled from IDLE.
- Latency, with REQx first sampled high at edge k:
  - SH_* valid after edge k.
  - RES and ACKx valid after edge k+1.
- Release: REQx sampled low at edge m (m >= k+2) -> ACKx low after edge m.
- Earliest next grant is edge m+1. Minimum turnaround is 3 cycles per operation.
- Back-to-back with both REQs held high: grants alternate 0, 1, 0, 1 (round-robin).

## Configuration
- SHIFT_ARB_FIXED_PRI_EN defined: fixed priority. When both REQs are high in IDLE, requester 0 always wins. LAST is still updated but has no effect on arbitration.
- SHIFT_ARB_FIXED_PRI_EN undefined (default): round-robin as described under Operation.

## Test plan
- Reset: hold RST low with REQ0 = 1 -> ACK0 = ACK1 = 0, RES = 0, SH_* = 0. Release RST -> ACK0 = 1 two edges later.
- Single right shifts, each with full handshake, requester 0:
  - D0 = 'b11000, S0 = 3, LNR0 = 0 -> RES = 'b11.
  - D0 = 'b100, S0 = 2 -> RES = 'b1.
  - D0 = 'b100, S0 = 3 -> RES = 0.
  - D0 = 1, S0 = 1 -> RES = 0.
- Left shift and large amount, requester 1:
  - D1 = 1, S1 = 31, LNR1 = 1 -> RES = 32'h80000000.
  - S1 = 40 -> RES = 0.
- Contention: REQ0 and REQ1 both high from reset release and re-raised immediately after each ACK -> grant order 0, 1, 0, 1. With SHIFT_ARB_FIXED_PRI_EN defined, the order is 0, 0, 0.
- Operand stability: change D0 from 5 to 7 one cycle after grant, S0 = 1, LNR0 = 1 -> RES = 10.
- Early release and mid-operation reset:
  - REQ0 dropped during ISSUE -> ACK0 high for exactly one cycle.
  - RST pulsed low during HOLD -> ACK0 and RES return to 0 immediately.
